fwd_hazard_scoreboard: RTL and testbench
========================================

Name: fwd_hazard_scoreboard

Overview:
Parametrised successor to the two-slot forwarding selector for the superscalar core. It tracks in-flight writers over a DEPTH-stage shadow pipeline and resolves a forward source (stage, lane) for every source operand of every issue slot. It also detects load-use and intra-bundle RAW hazards and produces an in-order issue mask. It sits between decode/issue and the operand-bypass muxes in front of the execute lanes.

Parameters:
ISSUE_W, 2, number of issue slots/lanes; slot 0 is oldest in program order
NUM_SRC, 2, source operands per slot
DEPTH, 2, tracked post-issue stages (stage 1 = EX, stage DEPTH = WB)
LOAD_RDY_STAGE, 2, first stage at which a load result is forwardable (2..DEPTH)
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  squash all tracked writers; block issue this cycle
in_valid  in  [ISSUE_W]  slot holds an instruction
in_rs  in  [ISSUE_W][NUM_SRC][5]  source register indices
in_rd  in  [ISSUE_W][5]  destination register
in_we  in  [ISSUE_W]  slot writes rd
in_is_load  in  [ISSUE_W]  slot is a load
issue_mask  out  [ISSUE_W]  slots issuing this cycle (prefix-contiguous)
stall  out  1  (in_valid & ~issue_mask) != 0
fwd_stage  out  [ISSUE_W][NUM_SRC][$clog2(DEPTH+1)]  0 = regfile, k = stage k
fwd_lane  out  [ISSUE_W][NUM_SRC][$clog2(ISSUE_W)]  producing lane within fwd_stage; 0 when fwd_stage = 0
stall_cnt  out  [CNT_W]  saturating count of stall cycles

Behaviour:
- Reset (async assert, sync release): all DEPTH×ISSUE_W entries invalid, stall_cnt = 0. With state empty: fwd_stage = 0, fwd_lane = 0. issue_mask is then determined by the intra-bundle rule only.
- Entry = {valid, rd, is_load}. Only entries with in_we = 1 and rd != 0 are valid; x0 never matches.
- Shift every cycle, no enable:
  - stage k+1 <= stage k.
  - stage 1 lane l <= slot l when issue_mask[l], else invalid (a bubble).
  - Stage DEPTH contents are dropped.
- flush: the next edge clears all stages; stage 1 also gets nothing. During the flush cycle issue_mask = 0, stall = 0, and stall_cnt holds.
- Forward select (combinational, zero latency):
  - For each operand, search stages 1..DEPTH for valid rd == rs.
  - The smallest stage number wins (youngest). Within a stage, the highest lane wins (younger in program order).
  - Result gives fwd_stage/fwd_lane.
- Load-use hazard: slot s is blocked if the winning match for any of its operands is a load at a stage < LOAD_RDY_STAGE. No fall-back to an older match.
- Intra-bundle hazard: slot s is blocked if any of its rs equals rd of an earlier slot j < s with in_valid[j], in_we[j] and rd != 0. The stale fwd output for slot s is don't-care when blocked.
- Issue mask:
  - issue_mask[0] = in_valid[0] & ~blocked[0].
  - issue_mask[s] = issue_mask[s-1] & in_valid[s] & ~blocked[s].
  - Upstream re-presents unissued slots next cycle, shifted down to slot 0.
- stall_cnt increments by 1 on each cycle with stall = 1 and flush = 0. It saturates at all-ones and never wraps.
- Outputs depend combinationally on inputs and state. There are no combinational paths from flush to fwd_*.

Decomposition:
- Package fwd_pkg: fwd_entry_t struct {valid, rd[4:0], is_load}; localparam widths STAGE_W = $clog2(DEPTH+1) and LANE_W = $clog2(ISSUE_W); typedef fwd_sel_t {stage, lane}.
- One sub-module, fwd_src_select: per-operand priority search over the entry array. It returns fwd_sel_t plus a load_not_ready flag and is instantiated ISSUE_W×NUM_SRC times.

Test Plan:
1. Reset, then slot0 add x5, slot1 uses rs x5 → issue_mask = 01, stall = 1. Next cycle, slot0 = that consumer → fwd_stage = 1, fwd_lane = 0, issue_mask = 01.
2. Cycle n: lanes 0 and 1 both write x7, non-load. Cycle n+1: consumer of x7 → fwd_stage = 1, fwd_lane = 1. Cycle n+2 re-present → fwd_stage = 2, lane 1. Cycle n+3 → fwd_stage = 0.
3. Load writing x3 issues. Next cycle, consumer of x3 → issue_mask = 0, stall = 1, stall_cnt +1. Following cycle → issues with fwd_stage = 2.
4. rd = x0 with we = 1, consumer rs = x0 → fwd_stage = 0, no stall in any stage.
5. flush asserted with an occupied pipeline → issue_mask = 0 that cycle. Next cycle all fwd_stage = 0. stall_cnt unchanged.
6. Force stall_cnt to all-ones (CNT_W = 4, 16+ stall cycles) → stays 15. Async rst_n mid-cycle → all outputs clear immediately.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and widths for the forwarding/hazard scoreboard.
// The widths here are tied to the FWD_* geometry. The scoreboard parameters must match it.
package fwd_pkg;

  localparam int unsigned FWD_ISSUE_W = 2;
  localparam int unsigned FWD_DEPTH   = 2;

  localparam int unsigned STAGE_W = $clog2(FWD_DEPTH + 1);
  localparam int unsigned LANE_W  = (FWD_ISSUE_W > 1) ? $clog2(FWD_ISSUE_W) : 1;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } fwd_entry_t;

  typedef struct packed {
    logic [STAGE_W-1:0] stage;
    logic [LANE_W-1:0]  lane;
  } fwd_sel_t;

endpackage

// File: rtl/fwd_src_select.sv
// Priority search of one source operand over the in-flight writer array.
// The youngest stage wins. Within that stage the highest lane wins.
module fwd_src_select
  import fwd_pkg::*;
#(
  parameter int unsigned ISSUE_W        = FWD_ISSUE_W,
  parameter int unsigned DEPTH          = FWD_DEPTH,
  parameter int unsigned LOAD_RDY_STAGE = 2
) (
  input  logic [4:0]                               rs_i,
  input  fwd_entry_t [DEPTH-1:0][ISSUE_W-1:0]      entries_i,
  output fwd_sel_t                                 sel_o,
  output logic                                     load_not_ready_o
);

  // Scan from oldest to youngest. The last hit overrides earlier ones, which gives the priority.
  always_comb begin
    sel_o            = '0;
    load_not_ready_o = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      for (int l = 0; l < ISSUE_W; l++) begin
        if (entries_i[k][l].valid && (rs_i != 5'd0) && (entries_i[k][l].rd == rs_i)) begin
          sel_o.stage      = STAGE_W'(k + 1);
          sel_o.lane       = LANE_W'(l);
          load_not_ready_o = entries_i[k][l].is_load && ((k + 1) < int'(LOAD_RDY_STAGE));
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Shadow pipeline of in-flight writers. It provides operand forward select,
// load-use and intra-bundle hazard detection, and an in-order issue mask.
module fwd_hazard_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned ISSUE_W        = FWD_ISSUE_W,
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned DEPTH          = FWD_DEPTH,
  parameter int unsigned LOAD_RDY_STAGE = 2,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          flush,
  input  logic [ISSUE_W-1:0]                            in_valid,
  input  logic [ISSUE_W-1:0][NUM_SRC-1:0][4:0]          in_rs,
  input  logic [ISSUE_W-1:0][4:0]                       in_rd,
  input  logic [ISSUE_W-1:0]                            in_we,
  input  logic [ISSUE_W-1:0]                            in_is_load,
  output logic [ISSUE_W-1:0]                            issue_mask,
  output logic                                          stall,
  output logic [ISSUE_W-1:0][NUM_SRC-1:0][STAGE_W-1:0]  fwd_stage,
  output logic [ISSUE_W-1:0][NUM_SRC-1:0][LANE_W-1:0]   fwd_lane,
  output logic [CNT_W-1:0]                              stall_cnt
);

  fwd_entry_t [DEPTH-1:0][ISSUE_W-1:0] pipe_q, pipe_d;
  logic [CNT_W-1:0]                    stall_cnt_q, stall_cnt_d;

  fwd_sel_t [ISSUE_W-1:0][NUM_SRC-1:0] sel;
  logic     [ISSUE_W-1:0][NUM_SRC-1:0] load_nr;
  logic     [ISSUE_W-1:0]              blocked;

  for (genvar s = 0; s < ISSUE_W; s++) begin : g_slot
    for (genvar n = 0; n < NUM_SRC; n++) begin : g_src
      fwd_src_select #(
        .ISSUE_W        (ISSUE_W),
        .DEPTH          (DEPTH),
        .LOAD_RDY_STAGE (LOAD_RDY_STAGE)
      ) u_sel (
        .rs_i             (in_rs[s][n]),
        .entries_i        (pipe_q),
        .sel_o            (sel[s][n]),
        .load_not_ready_o (load_nr[s][n])
      );
      assign fwd_stage[s][n] = sel[s][n].stage;
      assign fwd_lane[s][n]  = sel[s][n].lane;
    end
  end

  // A slot is blocked by a load-use hit on any of its operands, or by a RAW hazard on an
  // older slot in the same bundle.
  always_comb begin
    blocked = '0;
    for (int s = 0; s < ISSUE_W; s++) begin
      blocked[s] = |load_nr[s];
      for (int j = 0; j < s; j++) begin
        if (in_valid[j] && in_we[j] && (in_rd[j] != 5'd0)) begin
          for (int n = 0; n < NUM_SRC; n++) begin
            if (in_rs[s][n] == in_rd[j]) blocked[s] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    issue_mask = '0;
    if (!flush) begin
      issue_mask[0] = in_valid[0] & ~blocked[0];
      for (int s = 1; s < ISSUE_W; s++) begin
        issue_mask[s] = issue_mask[s-1] & in_valid[s] & ~blocked[s];
      end
    end
    stall = !flush && ((in_valid & ~issue_mask) != '0);
  end

  always_comb begin
    pipe_d = '0;
    if (!flush) begin
      for (int k = 1; k < DEPTH; k++) pipe_d[k] = pipe_q[k-1];
      for (int l = 0; l < ISSUE_W; l++) begin
        if (issue_mask[l] && in_we[l] && (in_rd[l] != 5'd0)) begin
          pipe_d[0][l] = '{valid: 1'b1, rd: in_rd[l], is_load: in_is_load[l]};
        end
      end
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      pipe_q      <= pipe_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed scenario bench for fwd_hazard_scoreboard (ISSUE_W=2, NUM_SRC=2, DEPTH=2, CNT_W=4).
module tb_fwd_hazard_scoreboard;

  logic                       clk;
  logic                       rst_n;
  logic                       flush;
  logic [1:0]                 in_valid;
  logic [1:0][1:0][4:0]       in_rs;
  logic [1:0][4:0]            in_rd;
  logic [1:0]                 in_we;
  logic [1:0]                 in_is_load;
  logic [1:0]                 issue_mask;
  logic                       stall;
  logic [1:0][1:0][1:0]       fwd_stage;
  logic [1:0][1:0][0:0]       fwd_lane;
  logic [3:0]                 stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_cnt = '0;

  fwd_hazard_scoreboard #(
    .ISSUE_W        (2),
    .NUM_SRC        (2),
    .DEPTH          (2),
    .LOAD_RDY_STAGE (2),
    .CNT_W          (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_rs      (in_rs),
    .in_rd      (in_rd),
    .in_we      (in_we),
    .in_is_load (in_is_load),
    .issue_mask (issue_mask),
    .stall      (stall),
    .fwd_stage  (fwd_stage),
    .fwd_lane   (fwd_lane),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int s, input logic v, input logic [4:0] r0, input logic [4:0] r1,
                          input logic [4:0] rd, input logic we, input logic ld);
    in_valid[s]   = v;
    in_rs[s][0]   = r0;
    in_rs[s][1]   = r1;
    in_rd[s]      = rd;
    in_we[s]      = we;
    in_is_load[s] = ld;
  endtask

  task automatic clear_inputs();
    flush = 1'b0;
    set_slot(0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    set_slot(1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    clear_inputs();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    #1;
    checks++; if (issue_mask !== 2'b00) begin errors++; $display("FAIL reset_mask got %b want 00", issue_mask); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
    checks++; if (fwd_stage !== '0) begin errors++; $display("FAIL reset_fwd got %h want 0", fwd_stage); end
  endtask

  task automatic test_intra_bundle();
    tick();
    set_slot(0, 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
    set_slot(1, 1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
    #1;
    checks++; if (issue_mask !== 2'b01) begin errors++; $display("FAIL intra_mask got %b want 01", issue_mask); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL intra_stall got %b want 1", stall); end
    tick();
    exp_cnt = exp_cnt + 4'd1;
    checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL intra_cnt got %0d want %0d", stall_cnt, exp_cnt); end
    set_slot(0, 1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
    set_slot(1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if (fwd_stage[0][0] !== 2'd1) begin errors++; $display("FAIL intra_fwd_stage got %0d want 1", fwd_stage[0][0]); end
    checks++; if (fwd_lane[0][0] !== 1'b0) begin errors++; $display("FAIL intra_fwd_lane got %0d want 0", fwd_lane[0][0]); end
    checks++; if (issue_mask !== 2'b01) begin errors++; $display("FAIL intra_reissue_mask got %b want 01", issue_mask); end
    drain();
  endtask

  task automatic test_lane_priority();
    set_slot(0, 1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
    set_slot(1, 1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
    #1;
    checks++; if (issue_mask !== 2'b11) begin errors++; $display("FAIL lane_issue got %b want 11", issue_mask); end
    tick();
    set_slot(0, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
    set_slot(1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if (fwd_stage[0][0] !== 2'd1) begin errors++; $display("FAIL lane_s1_stage got %0d want 1", fwd_stage[0][0]); end
    checks++; if (fwd_lane[0][0] !== 1'b1) begin errors++; $display("FAIL lane_s1_lane got %0d want 1", fwd_lane[0][0]); end
    checks++; if (issue_mask !== 2'b01) begin errors++; $display("FAIL lane_s1_mask got %b want 01", issue_mask); end
    tick();
    #1;
    checks++; if (fwd_stage[0][0] !== 2'd2) begin errors++; $display("FAIL lane_s2_stage got %0d want 2", fwd_stage[0][0]); end
    checks++; if (fwd_lane[0][0] !== 1'b1) begin errors++; $display("FAIL lane_s2_lane got %0d want 1", fwd_lane[0][0]); end
    tick();
    #1;
    checks++; if (fwd_stage[0][0] !== 2'd0) begin errors++; $display("FAIL lane_rf_stage got %0d want 0", fwd_stage[0][0]); end
    checks++; if (fwd_lane[0][0] !== 1'b0) begin errors++; $display("FAIL lane_rf_lane got %0d want 0", fwd_lane[0][0]); end
    drain();
  endtask

  task automatic test_load_use();
    set_slot(0, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    #1;
    checks++; if (issue_mask !== 2'b01) begin errors++; $display("FAIL load_issue got %b want 01", issue_mask); end
    tick();
    set_slot(0, 1'b1, 5'd3, 5'd0, 5'd8, 1'b1, 1'b0);
    #1;
    checks++; if (issue_mask !== 2'b00) begin errors++; $display("FAIL loaduse_mask got %b want 00", issue_mask); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL loaduse_stall got %b want 1", stall); end
    tick();
    exp_cnt = exp_cnt + 4'd1;
    checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL loaduse_cnt got %0d want %0d", stall_cnt, exp_cnt); end
    #1;
    checks++; if (issue_mask !== 2'b01) begin errors++; $display("FAIL loadready_mask got %b want 01", issue_mask); end
    checks++; if (fwd_stage[0][0] !== 2'd2) begin errors++; $display("FAIL loadready_stage got %0d want 2", fwd_stage[0][0]); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL loadready_stall got %b want 0", stall); end
    drain();
  endtask

  task automatic test_x0();
    set_slot(0, 1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
    set_slot(1, 1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0);
    #1;
    checks++; if (issue_mask !== 2'b11) begin errors++; $display("FAIL x0_intra_mask got %b want 11", issue_mask); end
    tick();
    set_slot(0, 1'b1, 5'd0, 5'd0, 5'd12, 1'b0, 1'b0);
    set_slot(1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if (fwd_stage[0][0] !== 2'd0) begin errors++; $display("FAIL x0_fwd got %0d want 0", fwd_stage[0][0]); end
    checks++; if (issue_mask !== 2'b01) begin errors++; $display("FAIL x0_mask got %b want 01", issue_mask); end
    drain();
  endtask

  task automatic test_flush();
    set_slot(0, 1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
    set_slot(1, 1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0);
    #1;
    checks++; if (issue_mask !== 2'b11) begin errors++; $display("FAIL flush_fill_mask got %b want 11", issue_mask); end
    tick();
    flush = 1'b1;
    set_slot(0, 1'b1, 5'd9, 5'd10, 5'd13, 1'b1, 1'b0);
    set_slot(1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if (issue_mask !== 2'b00) begin errors++; $display("FAIL flush_mask got %b want 00", issue_mask); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stall); end
    checks++; if (fwd_stage[0][1] !== 2'd1) begin errors++; $display("FAIL flush_fwd_live got %0d want 1", fwd_stage[0][1]); end
    checks++; if (fwd_lane[0][1] !== 1'b1) begin errors++; $display("FAIL flush_lane_live got %0d want 1", fwd_lane[0][1]); end
    tick();
    flush = 1'b0;
    #1;
    checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL flush_cnt got %0d want %0d", stall_cnt, exp_cnt); end
    checks++; if (fwd_stage !== '0) begin errors++; $display("FAIL flush_cleared got %h want 0", fwd_stage); end
    checks++; if (issue_mask !== 2'b01) begin errors++; $display("FAIL flush_after_mask got %b want 01", issue_mask); end
    drain();
  endtask

  task automatic test_saturate_and_async_reset();
    set_slot(0, 1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0);
    set_slot(1, 1'b1, 5'd4, 5'd0, 5'd14, 1'b1, 1'b0);
    repeat (20) tick();
    #1;
    checks++; if (stall_cnt !== 4'hf) begin errors++; $display("FAIL sat_cnt got %0d want 15", stall_cnt); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall got %b want 1", stall); end
    checks++; if (fwd_stage[1][0] !== 2'd1) begin errors++; $display("FAIL sat_fwd got %0d want 1", fwd_stage[1][0]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL arst_cnt got %0d want 0", stall_cnt); end
    checks++; if (fwd_stage !== '0) begin errors++; $display("FAIL arst_fwd got %h want 0", fwd_stage); end
    checks++; if (fwd_lane !== '0) begin errors++; $display("FAIL arst_lane got %h want 0", fwd_lane); end
    rst_n = 1'b1;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_intra_bundle();
    test_lane_priority();
    test_load_use();
    test_x0();
    test_flush();
    test_saturate_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
